// File: rtl/csc_row_gen.sv
// csc_row_gen: expands a latched first sparse row into all MAT_RANK circulant rows, columns kept ascending.
module csc_row_gen #(
    parameter int MAT_RANK = 256,
    localparam int INDEX_W = $clog2(MAT_RANK)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*INDEX_W-1:0] Scol_index,
    input  logic [31:0]          S_val_i0,
    input  logic [31:0]          S_val_i1,
    input  logic [31:0]          S_val_i2,
    input  logic [31:0]          S_val_i3,
    input  logic [31:0]          S_val_r0,
    input  logic [31:0]          S_val_r1,
    input  logic [31:0]          S_val_r2,
    input  logic [31:0]          S_val_r3,
    input  logic                 S_vld_o,
    output logic                 S_rdy_o,
    output logic [INDEX_W-1:0]   row_idx,
    output logic [4*INDEX_W-1:0] row_col,
    output logic [31:0]          row_val_i0,
    output logic [31:0]          row_val_i1,
    output logic [31:0]          row_val_i2,
    output logic [31:0]          row_val_i3,
    output logic [31:0]          row_val_r0,
    output logic [31:0]          row_val_r1,
    output logic [31:0]          row_val_r2,
    output logic [31:0]          row_val_r3,
    output logic                 row_nnz4,
    output logic                 row_last,
    output logic                 row_vld,
    input  logic                 row_rdy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [INDEX_W-1:0] lat_c_q [4];
    logic [31:0]        lat_i_q [4];
    logic [31:0]        lat_r_q [4];
    logic               nnz4_q;
    logic [INDEX_W-1:0] idx_q;
    logic [INDEX_W-1:0] col_q [4];
    logic [31:0]        vi_q [4];
    logic [31:0]        vr_q [4];
    logic               vld_q;
    logic [INDEX_W-1:0] in_c [4];
    logic [31:0]        in_i [4];
    logic [31:0]        in_r [4];
    logic               nnz_in, accept, adv, last_hs;
    logic [INDEX_W-1:0] nr;
    logic [INDEX_W:0]   s [4];
    logic [2:0]         w;
    logic [1:0]         rot, mask;
    logic [1:0]         src [4];
    logic               keep [4];
    logic [INDEX_W-1:0] nxt_c [4];
    logic [31:0]        nxt_i [4];
    logic [31:0]        nxt_r [4];

    assign in_i = '{S_val_i0, S_val_i1, S_val_i2, S_val_i3};
    assign in_r = '{S_val_r0, S_val_r1, S_val_r2, S_val_r3};
    assign nnz_in = |{Scol_index[4*INDEX_W-1:2*INDEX_W], S_val_i2, S_val_r2, S_val_i3, S_val_r3};
    assign accept = (state_q == IDLE) && S_vld_o;
    assign adv = (state_q == RUN) && vld_q && row_rdy;
    assign last_hs = adv && (idx_q == INDEX_W'(MAT_RANK - 1));
    assign nr = idx_q + 1'b1;
    assign mask = nnz4_q ? 2'd3 : 2'd1;

    // Wrapped entries are the highest input slots, so rotating them to the front keeps columns ascending.
    always_comb begin
        w = '0;
        for (int k = 0; k < 4; k++) begin
            in_c[k] = Scol_index[k*INDEX_W +: INDEX_W];
            s[k] = {1'b0, lat_c_q[k]} + {1'b0, nr};
            w = w + 3'(s[k][INDEX_W]);
        end
        rot = (2'd0 - w[1:0]) & mask;
        for (int j = 0; j < 4; j++) begin
            src[j] = (2'(j) + rot) & mask;
            keep[j] = nnz4_q || (j < 2);
            nxt_c[j] = keep[j] ? s[src[j]][INDEX_W-1:0] : '0;
            nxt_i[j] = keep[j] ? lat_i_q[src[j]] : '0;
            nxt_r[j] = keep[j] ? lat_r_q[src[j]] : '0;
        end
    end

    always_comb begin
        state_d = accept ? RUN : last_hs ? IDLE : state_q;
    end

    // Row 0 is the first row itself: an offset of zero never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nnz4_q  <= 1'b0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                lat_c_q[k] <= '0;
                lat_i_q[k] <= '0;
                lat_r_q[k] <= '0;
                col_q[k]   <= '0;
                vi_q[k]    <= '0;
                vr_q[k]    <= '0;
            end
        end else begin
            state_q <= state_d;
            vld_q   <= accept || (vld_q && !last_hs);
            if (accept) begin
                nnz4_q <= nnz_in;
                idx_q  <= '0;
                lat_c_q <= in_c;
                lat_i_q <= in_i;
                lat_r_q <= in_r;
                col_q   <= in_c;
                vi_q    <= in_i;
                vr_q    <= in_r;
            end else if (adv && !last_hs) begin
                idx_q <= nr;
                col_q <= nxt_c;
                vi_q  <= nxt_i;
                vr_q  <= nxt_r;
            end
        end
    end

    assign S_rdy_o    = (state_q == IDLE);
    assign row_idx    = idx_q;
    assign row_col    = {col_q[3], col_q[2], col_q[1], col_q[0]};
    assign row_val_i0 = vi_q[0];
    assign row_val_i1 = vi_q[1];
    assign row_val_i2 = vi_q[2];
    assign row_val_i3 = vi_q[3];
    assign row_val_r0 = vr_q[0];
    assign row_val_r1 = vr_q[1];
    assign row_val_r2 = vr_q[2];
    assign row_val_r3 = vr_q[3];
    assign row_nnz4   = nnz4_q;
    assign row_vld    = vld_q;
    assign row_last   = vld_q && (idx_q == INDEX_W'(MAT_RANK - 1));
endmodule

// File: tb/tb_csc_row_gen.sv
// tb_csc_row_gen: scoreboard bench for csc_row_gen at MAT_RANK=16.
module tb_csc_row_gen;
    localparam int N = 16;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4*W-1:0] Scol_index = '0;
    logic [31:0] S_val_i0 = '0, S_val_i1 = '0, S_val_i2 = '0, S_val_i3 = '0;
    logic [31:0] S_val_r0 = '0, S_val_r1 = '0, S_val_r2 = '0, S_val_r3 = '0;
    logic S_vld_o = 1'b0;
    logic S_rdy_o;
    logic [W-1:0] row_idx;
    logic [4*W-1:0] row_col;
    logic [31:0] row_val_i0, row_val_i1, row_val_i2, row_val_i3;
    logic [31:0] row_val_r0, row_val_r1, row_val_r2, row_val_r3;
    logic row_nnz4, row_last, row_vld;
    logic row_rdy = 1'b1;

    always #5 clk = ~clk;

    csc_row_gen #(.MAT_RANK(N)) dut (
        .clk(clk), .rst_n(rst_n), .Scol_index(Scol_index),
        .S_val_i0(S_val_i0), .S_val_i1(S_val_i1), .S_val_i2(S_val_i2), .S_val_i3(S_val_i3),
        .S_val_r0(S_val_r0), .S_val_r1(S_val_r1), .S_val_r2(S_val_r2), .S_val_r3(S_val_r3),
        .S_vld_o(S_vld_o), .S_rdy_o(S_rdy_o), .row_idx(row_idx), .row_col(row_col),
        .row_val_i0(row_val_i0), .row_val_i1(row_val_i1), .row_val_i2(row_val_i2), .row_val_i3(row_val_i3),
        .row_val_r0(row_val_r0), .row_val_r1(row_val_r1), .row_val_r2(row_val_r2), .row_val_r3(row_val_r3),
        .row_nnz4(row_nnz4), .row_last(row_last), .row_vld(row_vld), .row_rdy(row_rdy)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [15:0]  col;
        logic [127:0] vi;
        logic [127:0] vr;
        logic         nnz4;
        logic         last;
    } row_t;

    row_t q[$];
    row_t snap;
    int compared = 0;
    int mismatched = 0;
    int rdy_mode = 0;
    int hand_row = -1;
    logic [15:0] hand_col;
    logic [31:0] hand_vi0;
    logic stalled = 1'b0;
    logic expect_idle = 1'b0;

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic row_t dut_row();
        row_t e;
        e.idx  = row_idx;
        e.col  = row_col;
        e.vi   = {row_val_i3, row_val_i2, row_val_i1, row_val_i0};
        e.vr   = {row_val_r3, row_val_r2, row_val_r1, row_val_r0};
        e.nnz4 = row_nnz4;
        e.last = row_last;
        return e;
    endfunction

    // Reference: shift every column, then sort (column, value) pairs ascending.
    function automatic row_t model(input logic [15:0] idx, input logic [127:0] vi, input logic [127:0] vr, input int r);
        row_t e;
        int c[4];
        logic [31:0] a[4], b[4];
        int nv, tc;
        logic [31:0] ta, tb;
        logic nz;
        nz = (idx[15:8] != 0) || (vi[127:64] != 0) || (vr[127:64] != 0);
        nv = nz ? 4 : 2;
        for (int k = 0; k < 4; k++) begin
            c[k] = (int'(idx[k*4 +: 4]) + r) % N;
            a[k] = vi[k*32 +: 32];
            b[k] = vr[k*32 +: 32];
        end
        for (int i = 1; i < nv; i++)
            for (int j = i; j > 0 && c[j-1] > c[j]; j--) begin
                tc = c[j]; c[j] = c[j-1]; c[j-1] = tc;
                ta = a[j]; a[j] = a[j-1]; a[j-1] = ta;
                tb = b[j]; b[j] = b[j-1]; b[j-1] = tb;
            end
        e = '0;
        e.idx = 4'(r);
        for (int k = 0; k < nv; k++) begin
            e.col[k*4 +: 4] = 4'(c[k]);
            e.vi[k*32 +: 32] = a[k];
            e.vr[k*32 +: 32] = b[k];
        end
        e.nnz4 = nz;
        e.last = (r == N - 1);
        return e;
    endfunction

    task automatic drive_in(input logic [15:0] idx, input logic [127:0] vi, input logic [127:0] vr);
        Scol_index = idx;
        {S_val_i3, S_val_i2, S_val_i1, S_val_i0} = vi;
        {S_val_r3, S_val_r2, S_val_r1, S_val_r0} = vr;
    endtask

    task automatic send(input logic [15:0] idx, input logic [127:0] vi, input logic [127:0] vr);
        int t = 0;
        @(posedge clk); #1;
        drive_in(idx, vi, vr);
        S_vld_o = 1'b1;
        @(negedge clk);
        while (!S_rdy_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", S_rdy_o, 1);
        if (S_rdy_o)
            for (int r = 0; r < N; r++) q.push_back(model(idx, vi, vr, r));
        @(posedge clk); #1;
        S_vld_o = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        row_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom % 2) : (row_idx != 4'd7);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("rdy_after_last", S_rdy_o, 1);
                chk("vld_after_last", row_vld, 0);
                expect_idle = 1'b0;
            end
            if (stalled) chk("stall_hold", dut_row(), snap);
            stalled = row_vld && !row_rdy;
            snap = dut_row();
            if (row_vld && row_rdy) begin
                chk("row_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    row_t e;
                    e = q.pop_front();
                    chk("row", dut_row(), e);
                    if (e.last) expect_idle = 1'b1;
                end
                if (hand_row == int'(row_idx)) begin
                    chk("hand_col", row_col, hand_col);
                    chk("hand_vi0", row_val_i0, hand_vi0);
                end
            end
        end
    end

    localparam logic [127:0] VI_A = 128'h00000016_00000014_00000012_00000010;
    localparam logic [127:0] VR_A = 128'h00000017_00000015_00000013_00000011;

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_vld", row_vld, 0);
        chk("rst_rdy", S_rdy_o, 1);
        chk("rst_idx", row_idx, 0);
        chk("rst_col", row_col, 0);
        chk("rst_last", row_last, 0);
        chk("rst_nnz4", row_nnz4, 0);
        chk("rst_val", {row_val_i0, row_val_r3}, 0);
        rst_n = 1'b1;

        hand_row = 5; hand_col = 16'hE860; hand_vi0 = 32'h16;
        send(16'hB931, VI_A, VR_A);
        drain();

        rdy_mode = 1;
        send(16'hB931, VI_A, VR_A);
        @(posedge clk); #1;
        drive_in(16'h4321, ~VI_A, ~VR_A);
        S_vld_o = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rdy_in_run", S_rdy_o, 0);
        end
        @(posedge clk); #1;
        S_vld_o = 1'b0;
        drain();
        rdy_mode = 0;

        hand_row = 4; hand_col = 16'h0080; hand_vi0 = 32'h22;
        send(16'h00C4, 128'h00000022_00000020, 128'h00000023_00000021);
        drain();

        hand_row = 3; hand_col = 16'hB830; hand_vi0 = 32'h36;
        send(16'hD850, 128'h00000036_00000034_00000032_00000030, 128'h00000037_00000035_00000033_00000031);
        drain();

        hand_row = -1;
        rdy_mode = 2;
        send(16'hB931, VI_A, VR_A);
        t = 0;
        while (!(row_vld && row_idx == 4'd7) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reach_row7", {row_vld, row_idx}, {1'b1, 4'd7});
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_vld", row_vld, 0);
        chk("abort_rdy", S_rdy_o, 1);
        chk("abort_last", row_last, 0);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        rdy_mode = 0;
        hand_row = 5; hand_col = 16'hE860; hand_vi0 = 32'h16;
        send(16'hB931, VI_A, VR_A);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/csc_row_gen.md
Name: csc_row_gen

Overview:
- Sits directly downstream of the first-row sparse-vector generator. It consumes one packed first row per transaction: up to 4 complex non-zeros plus their column indices.
- It expands that row into all MAT_RANK rows of the circulant sparse matrix. Row r keeps the same values, with every column index shifted by r mod MAT_RANK.
- Rows stream out one per output handshake, with columns in ascending order, to the downstream sparse mat-vec stage.

Parameters:
MAT_RANK, 256, matrix rank N; must be a power of 2, >=8; INDEX_W = $clog2(MAT_RANK)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
Scol_index  input  4*INDEX_W  first-row column indices; slot k at [k*INDEX_W +: INDEX_W]; ascending within valid slots
S_val_i0..S_val_i3  input  32 each  imaginary part of first-row non-zero, slots 0..3
S_val_r0..S_val_r3  input  32 each  real part of first-row non-zero, slots 0..3
S_vld_o  input  1  upstream first row valid
S_rdy_o  output  1  this block ready to accept a first row
row_idx  output  INDEX_W  index of current output row
row_col  output  4*INDEX_W  column indices of current row, same slot packing, ascending
row_val_i0..row_val_i3  output  32 each  imaginary values, slot-aligned with row_col
row_val_r0..row_val_r3  output  32 each  real values, slot-aligned with row_col
row_nnz4  output  1  1 = 4 non-zeros in row; 0 = 2 non-zeros (slots 2,3 zero)
row_last  output  1  high with the row whose row_idx = MAT_RANK-1
row_vld  output  1  output row valid
row_rdy  input  1  downstream ready

Behaviour:
- Reset values: all outputs 0, except S_rdy_o = 1. State IDLE, row counter 0, latched first row cleared.
- rst_n low at any time, including mid-stream, aborts immediately. The partial stream is discarded; no row_last is issued.
- States and transitions:
  - IDLE: S_rdy_o = 1, row_vld = 0. On S_vld_o & S_rdy_o: latch indices, values and nnz4; go RUN. Register row 0 onto the outputs and assert row_vld on the next cycle (latency 1 cycle).
  - RUN: S_rdy_o = 0. While row_vld & !row_rdy, all row_* outputs hold stable.
  - RUN, on row_vld & row_rdy with row_idx != MAT_RANK-1: register row row_idx+1 on the same edge. row_vld stays 1, giving back-to-back rows at full throughput.
  - RUN, on row_vld & row_rdy with row_idx == MAT_RANK-1: row_vld <= 0, S_rdy_o <= 1, go IDLE.
  - A new first row is accepted only the cycle after returning to IDLE. There is no overlap of input and output transactions.
- nnz4 decode at input handshake:
  - nnz4 = 0 iff slot 2 and slot 3 indices are both 0 and all four of S_val_i2, S_val_r2, S_val_i3, S_val_r3 are 0.
  - Otherwise nnz4 = 1.
- Row r generation:
  - Shifted index c_k = (Scol_index slot k + r) mod MAT_RANK, using INDEX_W-bit wrap-around addition, for each valid slot.
  - w = number of valid slots whose shifted index wrapped (sum >= MAT_RANK).
  - Output slots are the valid slots rotated left by (nv - w) mod nv, where nv = 4 or 2. Wrapped entries therefore come first and columns stay ascending.
  - Values travel with their index.
  - When nnz4 = 0: row_col slots 2,3 = 0 and row_val_i/r 2,3 = 0.
- Values are passed through unmodified (no arithmetic on values). row_nnz4 is constant across the stream.
- row_last = (row_idx == MAT_RANK-1) & row_vld.

Test Plan:
- MAT_RANK=16; input idx {1,3,9,11}, vals 0x10..0x17, row_rdy=1 -> rows 0..15 back-to-back.
  - Row 0 = {1,3,9,11}.
  - Row 5 = {6,8,14,0} rotated to {0,6,8,14}, with slot-3 values first.
  - row_last only on row 15; S_rdy_o=1 the cycle after.
- Same input, row_rdy toggled randomly -> outputs stable while stalled, no row skipped or duplicated; row_idx sequence 0..15.
- nnz=2 input idx {4,12,0,0}, vals 2/3 all zero -> row_nnz4=0.
  - Row 4 = {8,0} rotated to {0,8}.
  - Slots 2,3 zero on every row.
- Wrap boundary: idx {0,5,8,13}, row 3 -> {3,8,11,0} rotated to {0,3,8,11}.
- Input offered during RUN -> S_rdy_o=0, no latch; the row stream is unaffected.
- rst_n asserted at row 7 mid-stall -> row_vld=0 and S_rdy_o=1 immediately. Next input restarts the stream at row_idx 0.
